mem_scan_engine: RTL and testbench
==================================

# mem_scan_engine

Parametrised, synthesizable memory sweep engine that generates read addresses for a synchronous-read word memory (Memoria32-style port: `raddress` in, `Dataout` out, fixed read latency). It walks from a programmable base to an inclusive limit with a fixed power-of-two stride, in single-pass or continuous-wrap mode. It accumulates a checksum and a word count of the returned data. It replaces ad-hoc bench address sweepers and also serves in-design as a memory scrub/verify engine beside the `up` core.

## Interface
Parameters:
- `ADDR_W`, 32: address width, byte addressing.
- `DATA_W`, 32: read data width.
- `STRIDE`, 4: address increment in bytes. Must be a power of two, ≥1.
- `RD_LAT`, 1: memory read latency in cycles, ≥1.
- `CNT_W`, 16: width of the word counter.

Ports:
- `clk` in 1: clock, rising-edge.
- `nrst` in 1: reset, asynchronous, active-high.
- `start` in 1: one-cycle request. Sampled only in IDLE.
- `abort` in 1: stop the scan. Sampled in RUN.
- `mode` in 1: 0 = single pass, 1 = wrap continuously until `abort`.
- `base_addr` in ADDR_W: first address. Captured on accepted `start`.
- `limit_addr` in ADDR_W: last address, inclusive. Captured on accepted `start`.
- `rd_addr` out ADDR_W: memory read address.
- `rd_en` out 1: read issued this cycle.
- `rd_data` in DATA_W: memory data, valid RD_LAT cycles after the matching `rd_en` cycle.
- `busy` out 1: scan in progress.
- `done` out 1: one-cycle completion pulse.
- `cfg_err` out 1: last request rejected. Held until the next accepted `start`.
- `word_cnt` out CNT_W: words accumulated in the current or last scan.
- `pass_cnt` out CNT_W: completed wraps in mode 1.
- `checksum` out DATA_W: sum of accumulated words, modulo 2^DATA_W.

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE: on `start`, capture `base_addr`, `limit_addr` and `mode`, then validate the configuration.
  - The configuration is invalid if `limit < base` (unsigned compare), or if either address has nonzero bits below log2(STRIDE).
  - Invalid: go to DONE with `cfg_err` = 1, `word_cnt` = 0, `checksum` = 0, and no `rd_en` issued.
  - Valid: clear the counters and checksum, clear `cfg_err`, go to RUN.
- RUN: each cycle, `rd_en` = 1 with `rd_addr` = the current address.
  - Address ≠ limit: next address = address + STRIDE.
  - Address = limit in mode 0: go to DRAIN.
  - Address = limit in mode 1: next address = base; `pass_cnt` increments when the limit read is issued.
  - The address compare is an equality test, so the adder never wraps past 2^ADDR_W.
- `abort` in RUN: no `rd_en` in that cycle. Go to DRAIN. Reads already in flight are still accumulated.
- DRAIN: `rd_en` = 0. Wait until the valid pipeline is empty, then go to DONE.
- DONE: `done` = 1 for one cycle, then go to IDLE.
- Accumulation: a valid shift register of depth RD_LAT tracks the issued reads.
  - When a tracked read's data is valid: `checksum += rd_data`, `word_cnt += 1`.
  - Both saturate? No: both wrap modulo 2^width.
- `start` in any state other than IDLE is ignored. `abort` outside RUN is ignored.
- Simultaneous `start` and `abort` in IDLE: `start` is accepted.
- Reset mid-scan: all state clears immediately and in-flight data is discarded.

## Timing
- Reset values: `rd_addr` 0, `rd_en` 0, `busy` 0, `done` 0, `cfg_err` 0, `word_cnt` 0, `pass_cnt` 0, `checksum` 0. FSM in IDLE.
- Accepted `start` sampled at edge E: first `rd_en`/`rd_addr`=base in the cycle after E. `busy` = 1 from that cycle.
- Single pass of N = (limit−base)/STRIDE + 1 words: `rd_en` high for exactly N consecutive cycles, no bubbles.
- Data for the read issued in cycle c is sampled at the end of cycle c+RD_LAT.
- `done` is asserted in the cycle after the last sample. Start-to-done latency is N+RD_LAT+1 cycles after E.
- `busy` is low in the `done` cycle. Outputs are valid and stable when `done` is high.
- Invalid configuration: `done` and `cfg_err` are asserted in the cycle after E. `busy` is never set.
- Mode 1: no bubble at the wrap; the cycle after `rd_addr` = limit has `rd_addr` = base.

## Structure
- Package `mem_scan_pkg`: `scan_state_e` (IDLE, RUN, DRAIN, DONE) and `scan_mode_e` (SCAN_ONCE, SCAN_WRAP).
- Sub-module `scan_valid_pipe`: RD_LAT-deep valid shift register.
  - Async-high reset.
  - Outputs `data_vld` and `empty`.
- All arithmetic is unsigned.
- The next-address adder is ADDR_W bits, with a carry-out that is never used.

## Test plan
- Single pass, RD_LAT=1, memory word i = i, base 0, limit 64, STRIDE 4: expect 17 reads at addresses 0..64, `word_cnt` = 17, `checksum` = 0x88, and `done` exactly 19 cycles after the `start` edge.
- Same stimulus with RD_LAT=3: expect identical results and `done` 2 cycles later.
- Mode 1, base 0x10, limit 0x18, 2 full passes then `abort`: expect the address sequence 10,14,18,10,… with no bubble, `pass_cnt` = 2, and every in-flight word counted.
- Invalid configurations:
  - limit 0x08 < base 0x20: expect `done` + `cfg_err` one cycle after `start`, with zero `rd_en` cycles.
  - base 0x02 (misaligned): expect the same response.
- `start` pulsed during RUN, and `nrst` asserted mid-scan:
  - The `start` pulse is ignored.
  - Reset: all outputs return to 0 asynchronously.
  - A following clean scan completes correctly.
- Limit at 0xFFFFFFFC, base 0xFFFFFFF0: expect 4 reads with no address rollover, and checksum wrap-around modulo 2^32 checked with data 0xFFFFFFFF.

Source files
------------

// File: rtl/mem_scan_pkg.sv
// Shared types for the memory sweep engine: controller states and scan modes.
package mem_scan_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } scan_state_e;

    typedef enum logic {
        SCAN_ONCE = 1'b0,
        SCAN_WRAP = 1'b1
    } scan_mode_e;

endpackage

// File: rtl/scan_valid_pipe.sv
// Valid-bit shift register that follows issued reads through the fixed
// memory latency; the oldest bit marks the cycle whose read data is valid.
module scan_valid_pipe #(
    parameter int RD_LAT = 1
) (
    input  logic clk,
    input  logic nrst,
    input  logic issue_i,
    output logic data_vld_o,
    output logic empty_o
);

    localparam logic [RD_LAT-1:0] OLDEST = RD_LAT'(1) << (RD_LAT - 1);

    logic [RD_LAT-1:0] vld_q;
    logic [RD_LAT-1:0] vld_d;

    assign vld_d      = (vld_q << 1) | RD_LAT'(issue_i);
    assign data_vld_o = vld_q[RD_LAT-1];
    // Empty means nothing remains in flight once the oldest entry retires this cycle.
    assign empty_o    = ((vld_q & ~OLDEST) == '0);

    always_ff @(posedge clk or posedge nrst) begin
        if (nrst) begin
            vld_q <= '0;
        end else begin
            vld_q <= vld_d;
        end
    end

endmodule

// File: rtl/mem_scan_engine.sv
// Memory sweep engine: issues strided reads from base to limit (once or
// wrapping) and accumulates a word count and checksum of the returned data.
module mem_scan_engine
    import mem_scan_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int STRIDE = 4,
    parameter int RD_LAT = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic              mode_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic [ADDR_W-1:0] limit_addr_i,
    output logic [ADDR_W-1:0] rd_addr_o,
    output logic              rd_en_o,
    input  logic [DATA_W-1:0] rd_data_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              cfg_err_o,
    output logic [CNT_W-1:0]  word_cnt_o,
    output logic [CNT_W-1:0]  pass_cnt_o,
    output logic [DATA_W-1:0] checksum_o
);

    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_RUN   = RUN;
    localparam logic [1:0] ST_DRAIN = DRAIN;
    localparam logic [1:0] ST_DONE  = DONE;

    localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(STRIDE - 1);
    localparam logic [ADDR_W-1:0] STRIDE_INC = ADDR_W'(STRIDE);

    logic [1:0]        state_q,    state_d;
    logic [ADDR_W-1:0] addr_q,     addr_d;
    logic [ADDR_W-1:0] base_q,     base_d;
    logic [ADDR_W-1:0] limit_q,    limit_d;
    scan_mode_e        mode_q,     mode_d;
    logic              cfg_err_q,  cfg_err_d;
    logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;
    logic [CNT_W-1:0]  pass_cnt_q, pass_cnt_d;
    logic [DATA_W-1:0] checksum_q, checksum_d;

    logic rd_en;
    logic data_vld;
    logic pipe_empty;
    logic cfg_bad;
    logic at_limit;

    assign cfg_bad  = (limit_addr_i < base_addr_i) ||
                      (((base_addr_i | limit_addr_i) & ALIGN_MASK) != '0);
    // Equality stop keeps the address adder from ever rolling past the top.
    assign at_limit = (addr_q == limit_q);
    assign rd_en    = (state_q == ST_RUN) && !abort_i;

    scan_valid_pipe #(.RD_LAT(RD_LAT)) u_valid_pipe (
        .clk        (clk),
        .nrst       (nrst),
        .issue_i    (rd_en),
        .data_vld_o (data_vld),
        .empty_o    (pipe_empty)
    );

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        base_d     = base_q;
        limit_d    = limit_q;
        mode_d     = mode_q;
        cfg_err_d  = cfg_err_q;
        word_cnt_d = word_cnt_q;
        pass_cnt_d = pass_cnt_q;
        checksum_d = checksum_q;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    base_d     = base_addr_i;
                    limit_d    = limit_addr_i;
                    mode_d     = scan_mode_e'(mode_i);
                    addr_d     = base_addr_i;
                    word_cnt_d = '0;
                    pass_cnt_d = '0;
                    checksum_d = '0;
                    cfg_err_d  = cfg_bad;
                    state_d    = cfg_bad ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (abort_i) begin
                    state_d = ST_DRAIN;
                end else if (!at_limit) begin
                    addr_d = addr_q + STRIDE_INC;
                end else if (mode_q == SCAN_WRAP) begin
                    addr_d     = base_q;
                    pass_cnt_d = pass_cnt_q + CNT_W'(1);
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (pipe_empty) begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (data_vld) begin
            word_cnt_d = word_cnt_q + CNT_W'(1);
            checksum_d = checksum_q + rd_data_i;
        end
    end

    always_ff @(posedge clk or posedge nrst) begin
        if (nrst) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            base_q     <= '0;
            limit_q    <= '0;
            mode_q     <= SCAN_ONCE;
            cfg_err_q  <= 1'b0;
            word_cnt_q <= '0;
            pass_cnt_q <= '0;
            checksum_q <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            base_q     <= base_d;
            limit_q    <= limit_d;
            mode_q     <= mode_d;
            cfg_err_q  <= cfg_err_d;
            word_cnt_q <= word_cnt_d;
            pass_cnt_q <= pass_cnt_d;
            checksum_q <= checksum_d;
        end
    end

    assign rd_addr_o  = addr_q;
    assign rd_en_o    = rd_en;
    assign busy_o     = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign done_o     = (state_q == ST_DONE);
    assign cfg_err_o  = cfg_err_q;
    assign word_cnt_o = word_cnt_q;
    assign pass_cnt_o = pass_cnt_q;
    assign checksum_o = checksum_q;

endmodule

// File: tb/tb_mem_scan_engine.sv
// Directed bench for mem_scan_engine: one instance at read latency 1 and one at
// latency 3 share stimulus; read addresses are checked against a scoreboard queue.
module tb_mem_scan_engine;

    logic        clk = 1'b0;
    logic        nrst = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        mode = 1'b0;
    logic [31:0] baseAddr = '0;
    logic [31:0] limitAddr = '0;

    logic [31:0] rdAddr1, rdData1, checksum1;
    logic [31:0] rdAddr3, rdData3, checksum3;
    logic        rdEn1, busy1, done1, cfgErr1;
    logic        rdEn3, busy3, done3, cfgErr3;
    logic [15:0] wordCnt1, passCnt1, wordCnt3, passCnt3;

    logic        memAllOnes = 1'b0;
    logic [31:0] d3a, d3b, d3c;
    logic [31:0] expAddrQ[$];

    int assertCount = 0;
    int failCount = 0;
    int done1At, done3At, rdCnt1, rdFirst1, rdLast1, rdCnt3;
    logic everBusy1, busyAtDone1, cfgErrAtDone1;

    always #5 clk = ~clk;

    mem_scan_engine #(.ADDR_W(32), .DATA_W(32), .STRIDE(4), .RD_LAT(1), .CNT_W(16)) u_dut1 (
        .clk(clk), .nrst(nrst), .start_i(start), .abort_i(abort), .mode_i(mode),
        .base_addr_i(baseAddr), .limit_addr_i(limitAddr),
        .rd_addr_o(rdAddr1), .rd_en_o(rdEn1), .rd_data_i(rdData1),
        .busy_o(busy1), .done_o(done1), .cfg_err_o(cfgErr1),
        .word_cnt_o(wordCnt1), .pass_cnt_o(passCnt1), .checksum_o(checksum1)
    );

    mem_scan_engine #(.ADDR_W(32), .DATA_W(32), .STRIDE(4), .RD_LAT(3), .CNT_W(16)) u_dut3 (
        .clk(clk), .nrst(nrst), .start_i(start), .abort_i(abort), .mode_i(mode),
        .base_addr_i(baseAddr), .limit_addr_i(limitAddr),
        .rd_addr_o(rdAddr3), .rd_en_o(rdEn3), .rd_data_i(rdData3),
        .busy_o(busy3), .done_o(done3), .cfg_err_o(cfgErr3),
        .word_cnt_o(wordCnt3), .pass_cnt_o(passCnt3), .checksum_o(checksum3)
    );

    // Memory word i holds i, or all ones for the wrap-around checksum case.
    function automatic logic [31:0] memWord(input logic [31:0] a);
        return memAllOnes ? 32'hFFFF_FFFF : {2'b00, a[31:2]};
    endfunction

    always @(posedge clk) begin
        rdData1 <= memWord(rdAddr1);
        d3a     <= memWord(rdAddr3);
        d3b     <= d3a;
        d3c     <= d3b;
    end
    assign rdData3 = d3c;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        assertCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Every issued read on the latency-1 instance must match the next expected address.
    always @(negedge clk) begin
        if (!nrst && rdEn1) begin
            checkOutput("rdQueue", 64'(expAddrQ.size() != 0), 64'd1);
            if (expAddrQ.size() != 0) begin
                checkOutput("rdAddr", 64'(rdAddr1), 64'(expAddrQ.pop_front()));
            end
        end
    end

    task automatic applyStimulus(input logic [31:0] b, input logic [31:0] l,
                                 input logic m, input int passes);
        logic [31:0] a;
        @(posedge clk); #1;
        for (int p = 0; p < passes; p++) begin
            a = b;
            forever begin
                expAddrQ.push_back(a);
                if (a == l) break;
                a = a + 32'd4;
            end
        end
        baseAddr  = b;
        limitAddr = l;
        mode      = m;
        start     = 1'b1;
        @(posedge clk); #1;
        start     = 1'b0;
    endtask

    // Cycle 1 is the cycle after the accepting edge; stops once both instances report done.
    task automatic runScan(input int maxCycles, input int abortAt);
        done1At = 0; done3At = 0; rdCnt1 = 0; rdFirst1 = 0; rdLast1 = 0; rdCnt3 = 0;
        everBusy1 = 1'b0; busyAtDone1 = 1'b0; cfgErrAtDone1 = 1'b0;
        for (int k = 1; k <= maxCycles; k++) begin
            abort = (k == abortAt);
            @(negedge clk);
            if (rdEn1) begin
                rdCnt1++;
                if (rdFirst1 == 0) rdFirst1 = k;
                rdLast1 = k;
            end
            if (rdEn3) rdCnt3++;
            if (busy1) everBusy1 = 1'b1;
            if (done1 && done1At == 0) begin
                done1At = k;
                busyAtDone1 = busy1;
                cfgErrAtDone1 = cfgErr1;
            end
            if (done3 && done3At == 0) done3At = k;
            if (done1At != 0 && done3At != 0) break;
            @(posedge clk); #1;
        end
        abort = 1'b0;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_rdAddr"},   64'(rdAddr1),   64'd0);
        checkOutput({tag, "_rdEn"},     64'(rdEn1),     64'd0);
        checkOutput({tag, "_busy"},     64'(busy1),     64'd0);
        checkOutput({tag, "_done"},     64'(done1),     64'd0);
        checkOutput({tag, "_cfgErr"},   64'(cfgErr1),   64'd0);
        checkOutput({tag, "_wordCnt"},  64'(wordCnt1),  64'd0);
        checkOutput({tag, "_passCnt"},  64'(passCnt1),  64'd0);
        checkOutput({tag, "_checksum"}, 64'(checksum1), 64'd0);
    endtask

    initial begin
        $display("[TB] reset values");
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkAllZero("rst");
        @(posedge clk); #1;
        nrst = 1'b0;

        $display("[TB] single pass 0..0x40");
        applyStimulus(32'h0, 32'h40, 1'b0, 1);
        runScan(60, 0);
        checkOutput("p1_rdCnt",     64'(rdCnt1),      64'd17);
        checkOutput("p1_rdFirst",   64'(rdFirst1),    64'd1);
        checkOutput("p1_rdLast",    64'(rdLast1),     64'd17);
        checkOutput("p1_doneAt",    64'(done1At),     64'd19);
        checkOutput("p1_busyDone",  64'(busyAtDone1), 64'd0);
        checkOutput("p1_everBusy",  64'(everBusy1),   64'd1);
        checkOutput("p1_wordCnt",   64'(wordCnt1),    64'd17);
        checkOutput("p1_checksum",  64'(checksum1),   64'h88);
        checkOutput("p1_passCnt",   64'(passCnt1),    64'd0);
        checkOutput("p1_queue",     64'(expAddrQ.size()), 64'd0);
        checkOutput("p1_lat3Rd",    64'(rdCnt3),      64'd17);
        checkOutput("p1_lat3Done",  64'(done3At),     64'd21);
        checkOutput("p1_lat3Words", 64'(wordCnt3),    64'd17);
        checkOutput("p1_lat3Sum",   64'(checksum3),   64'h88);

        $display("[TB] wrap mode, two passes then abort");
        applyStimulus(32'h10, 32'h18, 1'b1, 2);
        runScan(60, 7);
        checkOutput("w_rdCnt",      64'(rdCnt1),      64'd6);
        checkOutput("w_rdLast",     64'(rdLast1),     64'd6);
        checkOutput("w_passCnt",    64'(passCnt1),    64'd2);
        checkOutput("w_wordCnt",    64'(wordCnt1),    64'd6);
        checkOutput("w_checksum",   64'(checksum1),   64'h1E);
        checkOutput("w_doneAt",     64'(done1At),     64'd9);
        checkOutput("w_queue",      64'(expAddrQ.size()), 64'd0);
        checkOutput("w_lat3Words",  64'(wordCnt3),    64'd6);
        checkOutput("w_lat3Sum",    64'(checksum3),   64'h1E);
        checkOutput("w_lat3Pass",   64'(passCnt3),    64'd2);

        $display("[TB] invalid: limit below base");
        applyStimulus(32'h20, 32'h08, 1'b0, 0);
        runScan(10, 0);
        checkOutput("inv1_doneAt",  64'(done1At),       64'd1);
        checkOutput("inv1_cfgErr",  64'(cfgErrAtDone1), 64'd1);
        checkOutput("inv1_rdCnt",   64'(rdCnt1),        64'd0);
        checkOutput("inv1_busy",    64'(everBusy1),     64'd0);
        checkOutput("inv1_wordCnt", 64'(wordCnt1),      64'd0);
        checkOutput("inv1_sum",     64'(checksum1),     64'd0);
        checkOutput("inv1_lat3Done", 64'(done3At),      64'd1);

        $display("[TB] invalid: misaligned base");
        applyStimulus(32'h02, 32'h40, 1'b0, 0);
        runScan(10, 0);
        checkOutput("inv2_doneAt",  64'(done1At),       64'd1);
        checkOutput("inv2_cfgErr",  64'(cfgErrAtDone1), 64'd1);
        checkOutput("inv2_rdCnt",   64'(rdCnt1),        64'd0);
        checkOutput("inv2_busy",    64'(everBusy1),     64'd0);
        checkOutput("inv2_cfgHeld", 64'(cfgErr1),       64'd1);

        $display("[TB] start during run, then reset mid-scan");
        applyStimulus(32'h0, 32'h40, 1'b0, 1);
        for (int k = 1; k <= 6; k++) begin
            start    = (k == 4);
            baseAddr = (k == 4) ? 32'h100 : 32'h0;
            @(negedge clk);
            if (k == 6) begin
                checkOutput("rs_busy",    64'(busy1),     64'd1);
                checkOutput("rs_cfgErr",  64'(cfgErr1),   64'd0);
                checkOutput("rs_wordCnt", 64'(wordCnt1),  64'd4);
                checkOutput("rs_sum",     64'(checksum1), 64'd6);
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        nrst = 1'b1;
        #1;
        checkAllZero("rs_async");
        checkOutput("rs_lat3RdEn",  64'(rdEn3),    64'd0);
        checkOutput("rs_lat3Words", 64'(wordCnt3), 64'd0);
        expAddrQ.delete();
        @(posedge clk); #1;
        nrst = 1'b0;

        applyStimulus(32'h0, 32'h20, 1'b0, 1);
        runScan(60, 0);
        checkOutput("rc_rdCnt",    64'(rdCnt1),    64'd9);
        checkOutput("rc_doneAt",   64'(done1At),   64'd11);
        checkOutput("rc_wordCnt",  64'(wordCnt1),  64'd9);
        checkOutput("rc_checksum", 64'(checksum1), 64'h24);
        checkOutput("rc_queue",    64'(expAddrQ.size()), 64'd0);

        $display("[TB] top-of-space sweep with checksum wrap");
        memAllOnes = 1'b1;
        applyStimulus(32'hFFFF_FFF0, 32'hFFFF_FFFC, 1'b0, 1);
        runScan(60, 0);
        checkOutput("top_rdCnt",     64'(rdCnt1),    64'd4);
        checkOutput("top_doneAt",    64'(done1At),   64'd6);
        checkOutput("top_wordCnt",   64'(wordCnt1),  64'd4);
        checkOutput("top_checksum",  64'(checksum1), 64'hFFFF_FFFC);
        checkOutput("top_cfgErr",    64'(cfgErr1),   64'd0);
        checkOutput("top_queue",     64'(expAddrQ.size()), 64'd0);
        checkOutput("top_lat3Words", 64'(wordCnt3),  64'd4);
        checkOutput("top_lat3Sum",   64'(checksum3), 64'hFFFF_FFFC);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
